// File: rtl/uart_pkg.sv
// uart_pkg: shared register map, CON bit positions and FSM state type for the UART responder
package uart_pkg;
  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;
  localparam int CON_TX_IRQ_EN = 0;
  localparam int CON_RX_IRQ_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_VALID  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_FRAME_ERR = 5;
  localparam int CON_OVERRUN   = 6;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronises rxd, rejects short start glitches and samples 8N1 frames at mid-bit
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       done_o,
  output logic       err_o
);
  localparam int CW = $clog2(BAUD_DIV);
  uart_state_t state_q, state_d;
  logic [2:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic done_q, done_d, err_q, err_d;
  logic rx, fall, half, bit_end;
  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
  assign rx      = sync_q[1];
  assign fall    = sync_q[2] & ~sync_q[1];
  assign half    = cnt_q == CW'(BAUD_DIV / 2 - 1);
  assign bit_end = cnt_q == CW'(BAUD_DIV - 1);
  assign byte_o  = shift_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 3'b111;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rxd_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: if (half) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_d   = '0;
        shift_d = {rx, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (bit_end) begin
        cnt_d   = '0;
        done_d  = rx;
        err_d   = ~rx;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_bus_responder.sv
// uart_bus_responder: memory-mapped 8N1 UART with TXD/RXD/CON registers and level interrupt
module uart_bus_responder
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  localparam int CW = $clog2(BAUD_DIV);
  uart_state_t tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic [7:0] txd_q, txd_d, rxd_q, rxd_d;
  logic tx_en_q, tx_en_d, rx_en_q, rx_en_d;
  logic tx_done_q, tx_done_d, rx_valid_q, rx_valid_d;
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic rd_txd, rd_rxd, rd_con, wr_txd, wr_con;
  logic tx_busy, tx_bit_end, tx_last, accept;
  logic [7:0] rx_byte;
  logic rx_done, rx_err;
  logic [6:0] con;
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];
  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk   (clk),
    .reset (reset),
    .rxd_i (uart_rxd),
    .byte_o(rx_byte),
    .done_o(rx_done),
    .err_o (rx_err)
  );
  assign rd_txd     = rd & (addr == UART_TXD_ADDR);
  assign rd_rxd     = rd & (addr == UART_RXD_ADDR);
  assign rd_con     = rd & (addr == UART_CON_ADDR);
  assign wr_txd     = wr & (addr == UART_TXD_ADDR);
  assign wr_con     = wr & (addr == UART_CON_ADDR);
  assign tx_busy    = tx_state_q != IDLE;
  assign tx_bit_end = tx_cnt_q == CW'(BAUD_DIV - 1);
  assign tx_last    = (tx_state_q == STOP) & tx_bit_end;
  // a write landing on the final stop-bit edge chains the next frame without a gap
  assign accept     = wr_txd & (~tx_busy | tx_last);
  assign uart_txd   = tx_state_q == START ? 1'b0 : tx_state_q == DATA ? txd_q[tx_idx_q] : 1'b1;
  assign con        = {overrun_q, frame_err_q, tx_busy, rx_valid_q, tx_done_q, rx_en_q, tx_en_q};
  assign rdata      = rd_txd ? {24'd0, txd_q} : rd_rxd ? {24'd0, rxd_q} : rd_con ? {25'd0, con} : 32'd0;
  assign irqout     = (tx_done_q & tx_en_q) | (rx_valid_q & rx_en_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q  <= IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      txd_q       <= '0;
      rxd_q       <= '0;
      tx_en_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      txd_q       <= txd_d;
      rxd_q       <= rxd_d;
      tx_en_q     <= tx_en_d;
      rx_en_q     <= rx_en_d;
      tx_done_q   <= tx_done_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    case (tx_state_q)
      IDLE: tx_cnt_d = '0;
      START: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = DATA;
      end
      DATA: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_idx_d = tx_idx_q + 3'd1;
        if (tx_idx_q == 3'd7) tx_state_d = STOP;
      end
      STOP: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_state_d = IDLE;
      end
      default: tx_state_d = IDLE;
    endcase
    if (accept) begin
      tx_state_d = START;
      tx_cnt_d   = '0;
    end
  end
  // sets take priority over read-to-clear on the same edge
  always_comb begin
    txd_d       = accept ? wdata[7:0] : txd_q;
    rxd_d       = rx_done ? rx_byte : rxd_q;
    tx_en_d     = wr_con ? wdata[CON_TX_IRQ_EN] : tx_en_q;
    rx_en_d     = wr_con ? wdata[CON_RX_IRQ_EN] : rx_en_q;
    tx_done_d   = tx_last | (tx_done_q & ~rd_con);
    rx_valid_d  = rx_done | (rx_valid_q & ~rd_rxd);
    frame_err_d = rx_err | (frame_err_q & ~rd_con);
    overrun_d   = (rx_done & rx_valid_q) | (overrun_q & ~rd_con);
  end
endmodule

// File: tb/tb_uart_bus_responder.sv
// tb_uart_bus_responder: directed vectors and frame sequences for the UART responder at BAUD_DIV=16
module tb_uart_bus_responder;
  import uart_pkg::*;
  localparam int BD = 16;
  logic clk = 1'b0, reset = 1'b1, rd = 1'b0, wr = 1'b0, uart_rxd = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic irqout, uart_txd;
  int checks = 0, errors = 0;
  uart_bus_responder #(.BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irqout(irqout), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;
  vec_t vecs[13];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1; #1;
    d = rdata;
    rd = 1'b0; addr = '0;
  endtask
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1; #1;
    d = rdata;
    step(1);
    rd = 1'b0; addr = '0;
  endtask
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    step(1);
    wr = 1'b0; addr = '0; wdata = '0;
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BD) @(posedge clk);
    end
    uart_rxd = stop;
    repeat (BD) @(posedge clk);
    uart_rxd = 1'b1;
    step(4);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] d;
    logic [9:0] frame;
    vecs[0]  = '{1'b1, 1'b0, UART_CON_ADDR, 32'h0, 32'h04, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, UART_CON_ADDR, 32'h0, 32'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, UART_CON_ADDR, 32'hFF, 32'h00, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, UART_CON_ADDR, 32'h0, 32'h03, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, UART_TXD_ADDR, 32'h0, 32'hA5, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h4000_0024, 32'h0, 32'h00, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, UART_RXD_ADDR, 32'h0, 32'h00, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, UART_TXD_ADDR, 32'h0, 32'hA5, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, UART_CON_ADDR, 32'h0, 32'h03, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, UART_RXD_ADDR, 32'h55, 32'h00, 1'b0};
    vecs[10] = '{1'b1, 1'b0, UART_RXD_ADDR, 32'h0, 32'h00, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h4000_0019, 32'h0, 32'h00, 1'b0};
    vecs[12] = '{1'b0, 1'b1, UART_CON_ADDR, 32'h0, 32'h00, 1'b0};
    step(3);
    check("reset_txd", {31'd0, uart_txd}, 32'd1);
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq", {31'd0, irqout}, 32'd0);
    reset = 1'b0;
    step(1);
    peek(UART_CON_ADDR, d);
    check("reset_con", d, 32'h00);
    // TX 0xA5: start, LSB-first data, stop
    frame = {1'b1, 8'hA5, 1'b0};
    bus_write(UART_TXD_ADDR, 32'hA5);
    for (int i = 0; i < 10 * BD; i++) begin
      wr = (i == 40); addr = UART_TXD_ADDR; wdata = 32'h11;
      check($sformatf("tx_bit%0d_cyc%0d", i / BD, i % BD), {31'd0, uart_txd}, {31'd0, frame[i / BD]});
      if (i == 10 * BD - 1) begin
        peek(UART_CON_ADDR, d);
        check("tx_busy_last_cycle", d, 32'h10);
      end
      step(1);
    end
    wr = 1'b0; addr = '0; wdata = '0;
    peek(UART_CON_ADDR, d);
    check("tx_done_at_160", d, 32'h04);
    for (int i = 0; i < 13; i++) begin
      rd = vecs[i].rd; wr = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_irq", i), {31'd0, irqout}, {31'd0, vecs[i].exp_irq});
      step(1);
      rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    end
    send_rx(8'h3C, 1'b1);
    peek(UART_CON_ADDR, d);
    check("rx_valid_set", d, 32'h08);
    bus_read(UART_RXD_ADDR, d);
    check("rxd_3c", d, 32'h3C);
    bus_read(UART_CON_ADDR, d);
    check("rx_valid_cleared", d, 32'h00);
    send_rx(8'h11, 1'b1);
    send_rx(8'h7E, 1'b1);
    bus_read(UART_CON_ADDR, d);
    check("overrun_con", d, 32'h48);
    bus_read(UART_CON_ADDR, d);
    check("overrun_cleared", d, 32'h08);
    bus_read(UART_RXD_ADDR, d);
    check("rxd_7e", d, 32'h7E);
    send_rx(8'h22, 1'b1);
    send_rx(8'h5A, 1'b0);
    bus_read(UART_CON_ADDR, d);
    check("frame_err_con", d, 32'h28);
    bus_read(UART_RXD_ADDR, d);
    check("rxd_kept_22", d, 32'h22);
    uart_rxd = 1'b0;
    step(4);
    uart_rxd = 1'b1;
    step(40);
    peek(UART_CON_ADDR, d);
    check("glitch_con", d, 32'h00);
    peek(UART_RXD_ADDR, d);
    check("glitch_rxd", d, 32'h22);
    bus_write(UART_CON_ADDR, 32'h3);
    send_rx(8'h33, 1'b1);
    check("irq_rx", {31'd0, irqout}, 32'd1);
    bus_read(UART_RXD_ADDR, d);
    check("rxd_33", d, 32'h33);
    check("irq_rx_cleared", {31'd0, irqout}, 32'd0);
    bus_write(UART_TXD_ADDR, 32'h0F);
    step(10 * BD - 1);
    peek(UART_CON_ADDR, d);
    check("b2b_before", d, 32'h13);
    check("b2b_irq_before", {31'd0, irqout}, 32'd0);
    bus_write(UART_TXD_ADDR, 32'h81);
    check("b2b_start_bit", {31'd0, uart_txd}, 32'd0);
    peek(UART_CON_ADDR, d);
    check("b2b_con", d, 32'h17);
    check("irq_tx", {31'd0, irqout}, 32'd1);
    peek(UART_TXD_ADDR, d);
    check("b2b_txd", d, 32'h81);
    step(30);
    reset = 1'b1;
    step(1);
    check("midtx_reset_txd", {31'd0, uart_txd}, 32'd1);
    reset = 1'b0;
    check("midtx_reset_irq", {31'd0, irqout}, 32'd0);
    peek(UART_CON_ADDR, d);
    check("midtx_reset_con", d, 32'h00);
    step(1);
    check("idle_after_reset_txd", {31'd0, uart_txd}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
